vx_lsu_commit_arb: RTL and testbench

// - Downstream of the LSU: merges the load-commit and store-commit streams into one commit port feeding writeback/commit.
// - Round-robin arbitration between the two streams, with one registered output stage (1-cycle latency, full throughput).
// - Multi-beat load responses (eop=0 ... eop=1) are never interleaved with store commits.

---
 rtl/vx_lsu_commit_arb.sv | 146 ++++++++++++++
 tb/tb_vx_lsu_commit_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_lsu_commit_arb.sv
// Merges LSU load-commit and store-commit streams into one registered commit port.
// Round-robin between streams; multi-beat loads hold a lock. Optional perf counters: LSU_COMMIT_PERF_EN.
module vx_lsu_commit_arb #(
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int UUID_BITS   = 44
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [UUID_BITS-1:0]      ld_uuid,
  input  logic [NW_BITS-1:0]        ld_wid,
  input  logic [NUM_THREADS-1:0]    ld_tmask,
  input  logic [31:0]               ld_pc,
  input  logic [NR_BITS-1:0]        ld_rd,
  input  logic                      ld_wb,
  input  logic [NUM_THREADS*32-1:0] ld_data,
  input  logic                      ld_eop,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [UUID_BITS-1:0]      st_uuid,
  input  logic [NW_BITS-1:0]        st_wid,
  input  logic [NUM_THREADS-1:0]    st_tmask,
  input  logic [31:0]               st_pc,
  output logic                      cm_valid,
  input  logic                      cm_ready,
  output logic [UUID_BITS-1:0]      cm_uuid,
  output logic [NW_BITS-1:0]        cm_wid,
  output logic [NUM_THREADS-1:0]    cm_tmask,
  output logic [31:0]               cm_pc,
  output logic [NR_BITS-1:0]        cm_rd,
  output logic                      cm_wb,
  output logic [NUM_THREADS*32-1:0] cm_data,
  output logic                      cm_eop
`ifdef LSU_COMMIT_PERF_EN
  ,
  output logic [31:0]               perf_ld_stall_cycles,
  output logic [31:0]               perf_st_stall_cycles
`endif
);

  localparam logic RR_LD = 1'b0;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t state_reg, state_next;
  logic        lock;
  logic        rr_ptr;
  logic        load_en;
  logic        grant_ld, grant_st;
  logic        ld_fire, st_fire;

  assign load_en = ~cm_valid | cm_ready;

  // Store only wins when unlocked, and then only if loads are idle or it is its turn.
  always_comb begin
    grant_st = ~lock & st_valid & (~ld_valid | (rr_ptr != RR_LD));
    grant_ld = ~grant_st;
  end

  // Readies are held low while reset is asserted, not just after the next edge.
  assign ld_ready = reset & load_en & grant_ld;
  assign st_ready = reset & load_en & grant_st;
  assign ld_fire  = ld_valid & ld_ready;
  assign st_fire  = st_valid & st_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= UNLOCKED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      UNLOCKED: if (ld_fire && !ld_eop) state_next = LOCKED;
      LOCKED:   if (ld_fire && ld_eop)  state_next = UNLOCKED;
      default:  state_next = UNLOCKED;
    endcase
  end

  always_comb begin
    lock = (state_reg == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= RR_LD;
    end else if ((ld_fire && ld_eop) || st_fire) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cm_valid <= 1'b0;
      cm_uuid  <= '0;
      cm_wid   <= '0;
      cm_tmask <= '0;
      cm_pc    <= '0;
      cm_rd    <= '0;
      cm_wb    <= 1'b0;
      cm_data  <= '0;
      cm_eop   <= 1'b0;
    end else if (ld_fire) begin
      cm_valid <= 1'b1;
      cm_uuid  <= ld_uuid;
      cm_wid   <= ld_wid;
      cm_tmask <= ld_tmask;
      cm_pc    <= ld_pc;
      cm_rd    <= ld_rd;
      cm_wb    <= ld_wb;
      cm_data  <= ld_data;
      cm_eop   <= ld_eop;
    end else if (st_fire) begin
      cm_valid <= 1'b1;
      cm_uuid  <= st_uuid;
      cm_wid   <= st_wid;
      cm_tmask <= st_tmask;
      cm_pc    <= st_pc;
      cm_rd    <= '0;
      cm_wb    <= 1'b0;
      cm_data  <= '0;
      cm_eop   <= 1'b1;
    end else if (load_en) begin
      cm_valid <= 1'b0;
    end
  end

`ifdef LSU_COMMIT_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ld_stall_cycles <= '0;
      perf_st_stall_cycles <= '0;
    end else begin
      if (ld_valid && !ld_ready) perf_ld_stall_cycles <= perf_ld_stall_cycles + 32'd1;
      if (st_valid && !st_ready) perf_st_stall_cycles <= perf_st_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_lsu_commit_arb.sv
// Scoreboard bench for vx_lsu_commit_arb: expected commits are queued as stimulus is set up
// and popped when the commit port fires. Perf counters checked when LSU_COMMIT_PERF_EN is defined.
module tb_vx_lsu_commit_arb;

  typedef struct packed {
    logic [43:0]  uuid;
    logic [1:0]   wid;
    logic [3:0]   tmask;
    logic [31:0]  pc;
    logic [4:0]   rd;
    logic         wb;
    logic [127:0] data;
    logic         eop;
  } pkt_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         ld_valid, ld_ready;
  logic [43:0]  ld_uuid;
  logic [1:0]   ld_wid;
  logic [3:0]   ld_tmask;
  logic [31:0]  ld_pc;
  logic [4:0]   ld_rd;
  logic         ld_wb;
  logic [127:0] ld_data;
  logic         ld_eop;
  logic         st_valid, st_ready;
  logic [43:0]  st_uuid;
  logic [1:0]   st_wid;
  logic [3:0]   st_tmask;
  logic [31:0]  st_pc;
  logic         cm_valid, cm_ready;
  logic [43:0]  cm_uuid;
  logic [1:0]   cm_wid;
  logic [3:0]   cm_tmask;
  logic [31:0]  cm_pc;
  logic [4:0]   cm_rd;
  logic         cm_wb;
  logic [127:0] cm_data;
  logic         cm_eop;
`ifdef LSU_COMMIT_PERF_EN
  logic [31:0]  perf_ld_stall_cycles, perf_st_stall_cycles;
`endif

  pkt_t ld_src[$];
  pkt_t st_src[$];
  pkt_t exp_q[$];
  int   out_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc0;

  always #5 clk = ~clk;

  vx_lsu_commit_arb #(
    .NUM_THREADS(4), .NW_BITS(2), .NR_BITS(5), .UUID_BITS(44)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_uuid(ld_uuid), .ld_wid(ld_wid),
    .ld_tmask(ld_tmask), .ld_pc(ld_pc), .ld_rd(ld_rd), .ld_wb(ld_wb),
    .ld_data(ld_data), .ld_eop(ld_eop),
    .st_valid(st_valid), .st_ready(st_ready), .st_uuid(st_uuid), .st_wid(st_wid),
    .st_tmask(st_tmask), .st_pc(st_pc),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_uuid(cm_uuid), .cm_wid(cm_wid),
    .cm_tmask(cm_tmask), .cm_pc(cm_pc), .cm_rd(cm_rd), .cm_wb(cm_wb),
    .cm_data(cm_data), .cm_eop(cm_eop)
`ifdef LSU_COMMIT_PERF_EN
    ,
    .perf_ld_stall_cycles(perf_ld_stall_cycles),
    .perf_st_stall_cycles(perf_st_stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk_ld(input int uuid, input logic eop, input logic [3:0] tmask);
    pkt_t p;
    p.uuid  = 44'(uuid) | 44'h0AB_0000_0000;
    p.wid   = 2'(uuid);
    p.tmask = tmask;
    p.pc    = 32'h8000_0000 + 32'(uuid) * 4;
    p.rd    = 5'(uuid + 1);
    p.wb    = 1'b1;
    p.data  = {4{32'hA5A5_0000 ^ 32'(uuid)}};
    p.eop   = eop;
    return p;
  endfunction

  // Store packets carry the commit-side mapping already (rd/wb/data zero, eop set).
  function automatic pkt_t mk_st(input int uuid);
    pkt_t p;
    p.uuid  = 44'(uuid) | 44'h5C0_0000_0000;
    p.wid   = 2'(uuid + 2);
    p.tmask = 4'hF ^ 4'(uuid);
    p.pc    = 32'h4000_0000 + 32'(uuid) * 4;
    p.rd    = '0;
    p.wb    = 1'b0;
    p.data  = '0;
    p.eop   = 1'b1;
    return p;
  endfunction

  function automatic pkt_t cm_pkt();
    return {cm_uuid, cm_wid, cm_tmask, cm_pc, cm_rd, cm_wb, cm_data, cm_eop};
  endfunction

  task automatic drive();
    pkt_t lp, sp;
    lp = (ld_src.size() > 0) ? ld_src[0] : '0;
    sp = (st_src.size() > 0) ? st_src[0] : '0;
    ld_valid = (ld_src.size() > 0);
    ld_uuid  = lp.uuid;  ld_wid = lp.wid;  ld_tmask = lp.tmask; ld_pc = lp.pc;
    ld_rd    = lp.rd;    ld_wb  = lp.wb;   ld_data  = lp.data;  ld_eop = lp.eop;
    st_valid = (st_src.size() > 0);
    st_uuid  = sp.uuid;  st_wid = sp.wid;  st_tmask = sp.tmask; st_pc = sp.pc;
  endtask

  // One clock: sample at negedge, advance the sources just after posedge.
  task automatic cycle();
    logic lf, sf;
    pkt_t e;
    @(negedge clk);
    cyc++;
    if (cm_valid && cm_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_commit", {212'd0, cm_pkt().uuid}, 256'd0);
      end else begin
        e = exp_q.pop_front();
        $display("commit cyc=%0d uuid=%h eop=%0d wb=%0d", cyc, cm_uuid, cm_eop, cm_wb);
        check_eq("commit_pkt", 256'(cm_pkt()), 256'(e));
        out_cyc.push_back(cyc);
      end
    end
    check_eq("ready_exclusive", 256'(ld_ready & st_ready), 256'd0);
    lf = ld_valid & ld_ready;
    sf = st_valid & st_ready;
    @(posedge clk);
    #1;
    if (lf) void'(ld_src.pop_front());
    if (sf) void'(st_src.pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ld_src.delete();
    st_src.delete();
    exp_q.delete();
    drive();
    cycle();
    cycle();
    reset = 1'b1;
    out_cyc.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    check_eq({tag, "_drained"}, 256'(exp_q.size()), 256'd0);
    cycle();
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cm_ready = 1'b1;
    reset    = 1'b0;
    drive();
    ld_valid = 1'b1;
    st_valid = 1'b1;
    #12;
    check_eq("rst_ld_ready", 256'(ld_ready), 256'd0);
    check_eq("rst_st_ready", 256'(st_ready), 256'd0);
    check_eq("rst_cm_valid", 256'(cm_valid), 256'd0);
    check_eq("rst_cm_pkt", 256'(cm_pkt()), 256'd0);
    @(posedge clk);
    #1;
    drive();
    cycle();
    reset = 1'b1;

    // Load only: three single-beat loads, back to back.
    for (int i = 1; i <= 3; i++) begin
      ld_src.push_back(mk_ld(i, 1'b1, 4'hF));
      exp_q.push_back(mk_ld(i, 1'b1, 4'hF));
    end
    cyc0 = cyc;
    drive();
    drain("load_only");
    check_eq("load_count", 256'(out_cyc.size()), 256'd3);
    check_eq("load_latency", 256'(out_cyc[0] - cyc0), 256'd2);
    check_eq("load_tput", 256'(out_cyc[2] - out_cyc[0]), 256'd2);

    // Contention from reset: LD first, then strict alternation with no bubble.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      ld_src.push_back(mk_ld(10 + i, 1'b1, 4'h3));
      st_src.push_back(mk_st(20 + i));
      exp_q.push_back(mk_ld(10 + i, 1'b1, 4'h3));
      exp_q.push_back(mk_st(20 + i));
    end
    drive();
    drain("contention");
    check_eq("contention_count", 256'(out_cyc.size()), 256'd6);
    check_eq("contention_tput", 256'(out_cyc[5] - out_cyc[0]), 256'd5);

    // Lock: a three-beat load is not interleaved with a pending store.
    do_reset();
    ld_src.push_back(mk_ld(40, 1'b0, 4'b0001));
    ld_src.push_back(mk_ld(41, 1'b0, 4'b0010));
    ld_src.push_back(mk_ld(42, 1'b1, 4'b1100));
    st_src.push_back(mk_st(43));
    st_src.push_back(mk_st(44));
    exp_q.push_back(mk_ld(40, 1'b0, 4'b0001));
    exp_q.push_back(mk_ld(41, 1'b0, 4'b0010));
    exp_q.push_back(mk_ld(42, 1'b1, 4'b1100));
    exp_q.push_back(mk_st(43));
    exp_q.push_back(mk_st(44));
    drive();
    drain("lock");

    // Backpressure: held packet stays stable and both readies drop.
    do_reset();
    cm_ready = 1'b0;
    ld_src.push_back(mk_ld(50, 1'b1, 4'h5));
    st_src.push_back(mk_st(51));
    exp_q.push_back(mk_ld(50, 1'b1, 4'h5));
    exp_q.push_back(mk_st(51));
    drive();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("bp_cm_valid", 256'(cm_valid), 256'd1);
      check_eq("bp_cm_pkt", 256'(cm_pkt()), 256'(mk_ld(50, 1'b1, 4'h5)));
      check_eq("bp_readies", 256'({ld_ready, st_ready}), 256'd0);
    end
    cm_ready = 1'b1;
    drain("backpressure");
    check_eq("bp_release_tput", 256'(out_cyc[1] - out_cyc[0]), 256'd1);

    // Async reset mid-lock drops the held packet and clears the lock.
    do_reset();
    cm_ready = 1'b0;
    ld_src.push_back(mk_ld(60, 1'b0, 4'h1));
    st_src.push_back(mk_st(61));
    drive();
    cycle();
    cycle();
    check_eq("lock_st_stall", 256'(st_ready), 256'd0);
    check_eq("lock_cm_valid", 256'(cm_valid), 256'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_cm_valid", 256'(cm_valid), 256'd0);
    check_eq("async_cm_pkt", 256'(cm_pkt()), 256'd0);
    check_eq("async_st_ready", 256'(st_ready), 256'd0);
    ld_src.delete();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cm_ready = 1'b1;
    #1;
    check_eq("post_rst_st_grant", 256'(st_ready), 256'd1);
    exp_q.push_back(mk_st(61));
    out_cyc.delete();
    cyc0 = cyc;
    drain("post_reset");
    check_eq("post_rst_latency", 256'(out_cyc[0] - cyc0), 256'd2);

`ifdef LSU_COMMIT_PERF_EN
    // Store stalled behind a locked load with no load beat pending.
    do_reset();
    ld_src.push_back(mk_ld(70, 1'b0, 4'h8));
    exp_q.push_back(mk_ld(70, 1'b0, 4'h8));
    drive();
    cycle();
    st_src.push_back(mk_st(72));
    drive();
    repeat (4) cycle();
    check_eq("perf_st_stall", 256'(perf_st_stall_cycles), 256'd4);
    check_eq("perf_ld_stall", 256'(perf_ld_stall_cycles), 256'd0);
    ld_src.push_back(mk_ld(71, 1'b1, 4'h7));
    exp_q.push_back(mk_ld(71, 1'b1, 4'h7));
    exp_q.push_back(mk_st(72));
    drive();
    drain("perf");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
